piso_serializer: RTL and testbench

//   Parallel-in/serial-out front end for the SISO shift-register chain: accepts a

---
 rtl/piso_serializer.sv | 123 ++++++++++++
 tb/tb_piso_serializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end for a SISO shift-register chain.
// Accepts a WIDTH-bit word over valid/ready and emits one bit per clock with framing strobes.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I_DATA,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic             O,
    output logic             O_VALID,
    output logic             O_LAST
);

    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               o_q, o_d;
    logic               o_valid_q, o_valid_d;
    logic               o_last_q, o_last_d;
    logic               at_last;
    logic               accept;

    // Bit that goes onto O from a given shift-register image.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    // Ready while idle or while the last bit of the current word is on O (zero-gap reload).
    always_comb begin
        at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        I_READY = !RESET && ((state_q == IDLE) || at_last);
        accept  = I_VALID && I_READY;
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        o_d       = o_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;

        if (accept) begin
            state_d   = SHIFT;
            sr_d      = I_DATA;
            cnt_d     = '0;
            o_d       = head(I_DATA);
            o_valid_d = 1'b1;
            o_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    o_d       = 1'b0;
                    o_valid_d = 1'b0;
                    o_last_d  = 1'b0;
                end
                SHIFT: begin
                    if (at_last) begin
                        state_d   = IDLE;
                        sr_d      = '0;
                        cnt_d     = '0;
                        o_d       = 1'b0;
                        o_valid_d = 1'b0;
                        o_last_d  = 1'b0;
                    end else begin
                        sr_d      = shift_once(sr_q);
                        cnt_d     = cnt_q + CNT_W'(1);
                        o_d       = head(sr_d);
                        o_valid_d = 1'b1;
                        o_last_d  = (cnt_d == CNT_LAST);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    o_d       = 1'b0;
                    o_valid_d = 1'b0;
                    o_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
        end
    end

    assign O       = o_q;
    assign O_VALID = o_valid_q;
    assign O_LAST  = o_last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances share stimulus,
// and the MSB-first output also drives a 4-stage SISO chain checked against the model.
module tb_piso_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_data;
    logic         i_valid;
    logic         rdy_m, o_m, ov_m, ol_m;
    logic         rdy_l, o_l, ov_l, ol_l;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [1:0] q_msb[$];
    logic [1:0] q_lsb[$];
    bit         line[$];
    logic [3:0] chain = 4'h0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .RESET(rst), .I_DATA(i_data), .I_VALID(i_valid),
        .I_READY(rdy_m), .O(o_m), .O_VALID(ov_m), .O_LAST(ol_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .RESET(rst), .I_DATA(i_data), .I_VALID(i_valid),
        .I_READY(rdy_l), .O(o_l), .O_VALID(ov_l), .O_LAST(ol_l)
    );

    // Downstream SISO chain fed by the serial output.
    always @(posedge clk) begin
        if (mon_en) chain <= {chain[2:0], o_m};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bit stream for one accepted word: {last, bit} per cycle.
    task automatic push_word(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) q_msb.push_back({(i == 0), d[i]});
        for (int i = 0; i < W; i++) q_lsb.push_back({(i == W - 1), d[i]});
    endtask

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        i_valid = 1'b1;
        i_data  = d;
        while (!rdy_m && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: word %0h never accepted at %0t", d, $time);
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_word(d);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected bit per valid cycle, demands zero fill otherwise.
    always @(negedge clk) begin
        logic [1:0] e;
        logic       exp_o;
        logic       exp_rdy;
        if (mon_en) begin
            exp_rdy = !rst && (q_msb.size() <= 1);
            check("i_ready_msb", 32'(rdy_m), 32'(exp_rdy));
            check("i_ready_lsb", 32'(rdy_l), 32'(exp_rdy));

            if (q_msb.size() > 0) begin
                e = q_msb.pop_front();
                check("o_valid_msb", 32'(ov_m), 32'd1);
                check("o_msb", 32'(o_m), 32'(e[0]));
                check("o_last_msb", 32'(ol_m), 32'(e[1]));
                exp_o = e[0];
            end else begin
                check("idle_o_valid_msb", 32'(ov_m), 32'd0);
                check("idle_o_msb", 32'(o_m), 32'd0);
                check("idle_o_last_msb", 32'(ol_m), 32'd0);
                exp_o = 1'b0;
            end

            if (q_lsb.size() > 0) begin
                e = q_lsb.pop_front();
                check("o_valid_lsb", 32'(ov_l), 32'd1);
                check("o_lsb", 32'(o_l), 32'(e[0]));
                check("o_last_lsb", 32'(ol_l), 32'(e[1]));
            end else begin
                check("idle_o_valid_lsb", 32'(ov_l), 32'd0);
                check("idle_o_lsb", 32'(o_l), 32'd0);
                check("idle_o_last_lsb", 32'(ol_l), 32'd0);
            end

            check("siso_chain_out", 32'(chain[3]), 32'(line.pop_front()));
            line.push_back(exp_o);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        for (int i = 0; i < 4; i++) line.push_back(1'b0);

        // Reset held 3 cycles with I_VALID asserted: nothing may be accepted.
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h5A;
        @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        idle(2);

        // Single word.
        send(8'hA5);
        idle(3);

        // Back-to-back words, second accepted on the O_LAST cycle.
        send(8'hF0);
        send(8'h0F);
        idle(3);

        // Single set bit exercises both shift directions.
        send(8'h01);
        idle(3);

        // Mid-word reset: three bits out, then abort.
        send(8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        q_msb.delete();
        q_lsb.delete();
        #1 rst = 1'b0;
        idle(2);
        send(8'h3C);
        idle(2);

        // End-to-end stream with random gaps.
        for (int k = 0; k < 100; k++) begin
            d = W'($urandom);
            send(d);
            idle(int'($urandom_range(0, 3)));
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
